pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_W, default 5, register-index width.
REQ-002 SHALL have parameter CNT_W, default 32, stall performance-counter width.
REQ-003 SHALL have parameter MEM_TIMEOUT, default 256, consecutive memory-freeze cycles before a timeout is flagged.
REQ-004 SHALL have the following ports (one clock; reset is synchronous and active-high):
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  synchronous active-high reset
- id_rs1_i, id_rs2_i  in  REG_W  source registers of the instruction in ID
- id_rs1_used_i, id_rs2_used_i  in  1  source actually read
- ex_rd_i  in  REG_W  destination register of the instruction in EX
- ex_is_load_i  in  1  EX instruction is a load
- ex_redirect_i  in  1  EX resolved a taken branch, jump or mispredict
- mdu_start_i  in  1  EX issues a multi-cycle mul/div
- mdu_done_i  in  1  mul/div result ready (1-cycle pulse)
- dmem_req_i  in  1  MEM stage data-memory request
- dmem_ack_i  in  1  data-memory acknowledge
- pc_stall_o, ifid_stall_o, idex_stall_o, exmem_stall_o, memwb_stall_o  out  1  hold stage register
- ifid_flush_o, idex_flush_o, exmem_flush_o, memwb_flush_o  out  1  load bubble into stage register
- mdu_busy_o  out  1  FSM in MDU_WAIT
- mem_timeout_o  out  1  sticky memory-timeout error
- stall_cnt_o  out  CNT_W  count of cycles with pc_stall_o high

Function
REQ-005 SHALL implement FSM states RUN and MDU_WAIT; mdu_busy_o high exactly in MDU_WAIT.
REQ-006 SHALL decode mem_freeze = dmem_req_i & ~dmem_ack_i combinationally in every state; zero-wait ack (req and ack same cycle) SHALL cause no freeze.
REQ-007 SHALL, on mem_freeze, assert pc/ifid/idex/exmem stall and memwb_flush, all other outputs low; mem_freeze SHALL override every other condition.
REQ-008 SHALL, in RUN with no mem_freeze and mdu_start_i & ~mdu_done_i, assert pc/ifid/idex stall and exmem_flush, and enter MDU_WAIT next edge.
REQ-009 SHALL, in MDU_WAIT, keep the REQ-008 outputs until the done condition holds; in that cycle release all outputs (RUN behaviour) and return to RUN next edge.
REQ-010 SHALL define done condition = mdu_done_i | done_seen, where done_seen is a flag set by mdu_done_i arriving during mem_freeze in MDU_WAIT, and cleared on return to RUN.
REQ-011 SHALL treat mdu_start_i & mdu_done_i in the same RUN cycle as single-cycle: no stall, stay in RUN.
REQ-012 SHALL, in RUN with no mem_freeze/MDU condition and ex_redirect_i high, assert ifid_flush and idex_flush only.
REQ-013 SHALL detect load-use = ex_is_load_i & ex_rd_i!=0 & ((id_rs1_used_i & id_rs1_i==ex_rd_i) | (id_rs2_used_i & id_rs2_i==ex_rd_i)); if no higher-priority condition, assert pc_stall, ifid_stall, idex_flush for that cycle.
REQ-014 SHALL apply priority mem_freeze > MDU > redirect > load-use; redirect SHALL suppress load-use; mdu_start_i with ex_redirect_i SHALL take the MDU path.
REQ-015 SHALL increment stall_cnt_o on each edge where pc_stall_o is high, wrapping from all-ones to 0.
REQ-016 SHALL count consecutive mem_freeze cycles (saturating), clear it on any non-freeze cycle, and set mem_timeout_o when the count reaches MEM_TIMEOUT; mem_timeout_o SHALL stay set until reset.
REQ-017 SHALL never assert a stall and a flush for the same stage register in the same cycle.

Reset
REQ-018 SHALL, while rst_i is high, drive all stall/flush outputs to 0 regardless of inputs.
REQ-019 SHALL, on an edge with rst_i high, set state RUN, done_seen 0, freeze counter 0, stall_cnt_o 0, mem_timeout_o 0; reset mid-MDU_WAIT SHALL abandon the wait.

Verification
REQ-020 Load-use: ex_is_load_i=1, ex_rd_i=5, id_rs2_i=5, id_rs2_used_i=1 for one cycle -> pc_stall=ifid_stall=idex_flush=1 that cycle only, stall_cnt_o 0->1.
REQ-021 Redirect plus load-use in same cycle -> ifid_flush=idex_flush=1, pc_stall=0, stall_cnt_o unchanged.
REQ-022 mdu_start_i at cycle 0, mdu_done_i at cycle 4 -> stalls and exmem_flush high cycles 0-3, mdu_busy_o high cycles 1-4, all outputs low cycle 4, stall_cnt_o=4.
REQ-023 In MDU_WAIT, dmem_req_i=1, ack=0 for 3 cycles with mdu_done_i pulsing in the second -> mem-freeze outputs 3 cycles, then release on the cycle ack arrives, RUN next edge.
REQ-024 MEM_TIMEOUT=4, dmem_req_i=1, ack=0 held 6 cycles -> mem_timeout_o rises after 4th freeze cycle and stays high after ack; rst_i clears it.
REQ-025 rst_i asserted during MDU_WAIT with mem_freeze active -> all outputs 0 that cycle, state RUN and stall_cnt_o 0 after the edge.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for a five-stage in-order pipeline: arbitrates memory freeze,
// multi-cycle mul/div waits, control redirects and load-use interlocks.
module pipe_hazard_ctrl #(
    parameter int REG_W       = 5,
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 256
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [REG_W-1:0] id_rs1_i,
    input  logic [REG_W-1:0] id_rs2_i,
    input  logic             id_rs1_used_i,
    input  logic             id_rs2_used_i,
    input  logic [REG_W-1:0] ex_rd_i,
    input  logic             ex_is_load_i,
    input  logic             ex_redirect_i,
    input  logic             mdu_start_i,
    input  logic             mdu_done_i,
    input  logic             dmem_req_i,
    input  logic             dmem_ack_i,
    output logic             pc_stall_o,
    output logic             ifid_stall_o,
    output logic             idex_stall_o,
    output logic             exmem_stall_o,
    output logic             memwb_stall_o,
    output logic             ifid_flush_o,
    output logic             idex_flush_o,
    output logic             exmem_flush_o,
    output logic             memwb_flush_o,
    output logic             mdu_busy_o,
    output logic             mem_timeout_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam int FCNT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_MDU_WAIT = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic               done_seen_q, done_seen_d;
    logic [FCNT_W-1:0]  freeze_cnt_q, freeze_cnt_d;
    logic               timeout_q, timeout_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

    logic mem_freeze_s;
    logic load_use_s;
    logic done_s;
    logic run_release_s;
    logic pc_stall_s, ifid_stall_s, idex_stall_s, exmem_stall_s, memwb_stall_s;
    logic ifid_flush_s, idex_flush_s, exmem_flush_s, memwb_flush_s;

    // Hazard condition decode, independent of FSM state.
    always_comb begin
        mem_freeze_s = dmem_req_i & ~dmem_ack_i;
        load_use_s   = ex_is_load_i & (ex_rd_i != {REG_W{1'b0}}) &
                       ((id_rs1_used_i & (id_rs1_i == ex_rd_i)) |
                        (id_rs2_used_i & (id_rs2_i == ex_rd_i)));
        done_s       = mdu_done_i | done_seen_q;
    end

    // Priority arbitration and FSM next state; reset forces every stall/flush low.
    always_comb begin
        state_d       = state_q;
        done_seen_d   = done_seen_q;
        run_release_s = 1'b0;
        pc_stall_s    = 1'b0;
        ifid_stall_s  = 1'b0;
        idex_stall_s  = 1'b0;
        exmem_stall_s = 1'b0;
        memwb_stall_s = 1'b0;
        ifid_flush_s  = 1'b0;
        idex_flush_s  = 1'b0;
        exmem_flush_s = 1'b0;
        memwb_flush_s = 1'b0;
        if (rst_i) begin
            state_d     = ST_RUN;
            done_seen_d = 1'b0;
        end else if (mem_freeze_s) begin
            // A done pulse hidden behind a freeze must not be lost.
            pc_stall_s    = 1'b1;
            ifid_stall_s  = 1'b1;
            idex_stall_s  = 1'b1;
            exmem_stall_s = 1'b1;
            memwb_flush_s = 1'b1;
            if ((state_q == ST_MDU_WAIT) && mdu_done_i) begin
                done_seen_d = 1'b1;
            end else begin
                done_seen_d = done_seen_q;
            end
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (mdu_start_i && !mdu_done_i) begin
                        state_d = ST_MDU_WAIT;
                    end else begin
                        run_release_s = 1'b1;
                    end
                end
                ST_MDU_WAIT: begin
                    if (done_s) begin
                        state_d       = ST_RUN;
                        done_seen_d   = 1'b0;
                        run_release_s = 1'b1;
                    end else begin
                        state_d = ST_MDU_WAIT;
                    end
                end
                default: begin
                    state_d     = ST_RUN;
                    done_seen_d = 1'b0;
                end
            endcase

            if (run_release_s) begin
                if (ex_redirect_i) begin
                    ifid_flush_s = 1'b1;
                    idex_flush_s = 1'b1;
                end else if (load_use_s) begin
                    pc_stall_s   = 1'b1;
                    ifid_stall_s = 1'b1;
                    idex_flush_s = 1'b1;
                end else begin
                    pc_stall_s = 1'b0;
                end
            end else if (state_d == ST_MDU_WAIT) begin
                pc_stall_s    = 1'b1;
                ifid_stall_s  = 1'b1;
                idex_stall_s  = 1'b1;
                exmem_flush_s = 1'b1;
            end else begin
                pc_stall_s = 1'b0;
            end
        end
    end

    // Freeze-duration watchdog and stall performance counter.
    always_comb begin
        if (mem_freeze_s) begin
            if (freeze_cnt_q != FCNT_W'(MEM_TIMEOUT)) begin
                freeze_cnt_d = freeze_cnt_q + FCNT_W'(1);
            end else begin
                freeze_cnt_d = freeze_cnt_q;
            end
        end else begin
            freeze_cnt_d = {FCNT_W{1'b0}};
        end
        timeout_d = timeout_q |
                    (mem_freeze_s && (freeze_cnt_q >= FCNT_W'(MEM_TIMEOUT - 1)));
        if (pc_stall_s) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_RUN;
            done_seen_q  <= 1'b0;
            freeze_cnt_q <= {FCNT_W{1'b0}};
            timeout_q    <= 1'b0;
            stall_cnt_q  <= {CNT_W{1'b0}};
        end else begin
            state_q      <= state_d;
            done_seen_q  <= done_seen_d;
            freeze_cnt_q <= freeze_cnt_d;
            timeout_q    <= timeout_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign pc_stall_o    = pc_stall_s;
    assign ifid_stall_o  = ifid_stall_s;
    assign idex_stall_o  = idex_stall_s;
    assign exmem_stall_o = exmem_stall_s;
    assign memwb_stall_o = memwb_stall_s;
    assign ifid_flush_o  = ifid_flush_s;
    assign idex_flush_o  = idex_flush_s;
    assign exmem_flush_o = exmem_flush_s;
    assign memwb_flush_o = memwb_flush_s;
    assign mdu_busy_o    = (state_q == ST_MDU_WAIT);
    assign mem_timeout_o = timeout_q;
    assign stall_cnt_o   = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios with literal
// expectations followed by randomized traffic against a behavioural model.
module tb_pipe_hazard_ctrl;

    localparam int REG_W = 5;
    localparam int CNT_W = 4;
    localparam int MEM_TIMEOUT = 4;

    logic clk = 1'b0;
    logic rst;
    logic [REG_W-1:0] rs1, rs2, rd;
    logic u1, u2, is_load, redirect, mdu_start, mdu_done, dmem_req, dmem_ack;
    logic pc_stall, ifid_stall, idex_stall, exmem_stall, memwb_stall;
    logic ifid_flush, idex_flush, exmem_flush, memwb_flush;
    logic mdu_busy, mem_timeout;
    logic [CNT_W-1:0] stall_cnt;

    int checks = 0;
    int failures = 0;

    // model state
    bit m_busy = 1'b0;
    bit m_done_seen = 1'b0;
    int m_run = 0;
    bit m_timeout = 1'b0;
    int m_cnt = 0;
    bit e_pc_cur = 1'b0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk_i(clk), .rst_i(rst),
        .id_rs1_i(rs1), .id_rs2_i(rs2),
        .id_rs1_used_i(u1), .id_rs2_used_i(u2),
        .ex_rd_i(rd), .ex_is_load_i(is_load), .ex_redirect_i(redirect),
        .mdu_start_i(mdu_start), .mdu_done_i(mdu_done),
        .dmem_req_i(dmem_req), .dmem_ack_i(dmem_ack),
        .pc_stall_o(pc_stall), .ifid_stall_o(ifid_stall), .idex_stall_o(idex_stall),
        .exmem_stall_o(exmem_stall), .memwb_stall_o(memwb_stall),
        .ifid_flush_o(ifid_flush), .idex_flush_o(idex_flush),
        .exmem_flush_o(exmem_flush), .memwb_flush_o(memwb_flush),
        .mdu_busy_o(mdu_busy), .mem_timeout_o(mem_timeout), .stall_cnt_o(stall_cnt)
    );

    task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // Expected outputs from the priority rules, checked every cycle at negedge.
    always @(negedge clk) begin
        logic fz, lu, dn;
        logic [4:0] es, as;
        logic [3:0] ef, af;
        fz = dmem_req && !dmem_ack;
        lu = is_load && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
        dn = mdu_done || m_done_seen;
        es = 5'b00000;
        ef = 4'b0000;
        if (!rst) begin
            if (fz) begin
                es = 5'b11110; ef = 4'b0001;
            end else if ((m_busy && !dn) || (!m_busy && mdu_start && !mdu_done)) begin
                es = 5'b11100; ef = 4'b0010;
            end else if (redirect) begin
                ef = 4'b1100;
            end else if (lu) begin
                es = 5'b11000; ef = 4'b0100;
            end
        end
        e_pc_cur = es[4];
        as = {pc_stall, ifid_stall, idex_stall, exmem_stall, memwb_stall};
        af = {ifid_flush, idex_flush, exmem_flush, memwb_flush};
        checks++;
        if ({as, af, mdu_busy, mem_timeout, stall_cnt} !== {es, ef, m_busy, m_timeout, CNT_W'(m_cnt)}) begin
            failures++;
            $display("FAIL model t=%0t actual=%b_%b_%b%b_%0d expected=%b_%b_%b%b_%0d", $time,
                     as, af, mdu_busy, mem_timeout, stall_cnt, es, ef, m_busy, m_timeout, m_cnt);
        end
        checks++;
        if ((as[3:0] & af) !== 4'b0000) begin
            failures++;
            $display("FAIL stall_flush_overlap actual=%b expected=0000", as[3:0] & af);
        end
    end

    // Model state update on each rising edge.
    always @(posedge clk) begin
        if (rst) begin
            m_busy = 1'b0; m_done_seen = 1'b0; m_run = 0; m_timeout = 1'b0; m_cnt = 0;
        end else begin
            if (e_pc_cur) m_cnt = (m_cnt + 1) % 16;
            if (dmem_req && !dmem_ack) begin
                if (m_run < 1000) m_run = m_run + 1;
                if (m_run >= MEM_TIMEOUT) m_timeout = 1'b1;
                if (m_busy && mdu_done) m_done_seen = 1'b1;
            end else begin
                m_run = 0;
                if (m_busy && (mdu_done || m_done_seen)) begin
                    m_busy = 1'b0; m_done_seen = 1'b0;
                end else if (!m_busy && mdu_start && !mdu_done) begin
                    m_busy = 1'b1;
                end
            end
        end
    end

    task automatic idle();
        rs1 = 0; rs2 = 0; rd = 0; u1 = 0; u2 = 0; is_load = 0; redirect = 0;
        mdu_start = 0; mdu_done = 0; dmem_req = 0; dmem_ack = 0;
    endtask

    task automatic nxt();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        idle(); rst = 1; nxt(); rst = 0;
    endtask

    initial begin
        int stuck;
        idle(); rst = 1;
        nxt(); nxt();
        @(negedge clk);
        lit("reset_cnt", stall_cnt, 0);
        lit("reset_busy", mdu_busy, 0);
        lit("reset_timeout", mem_timeout, 0);
        lit("reset_pc_stall", pc_stall, 0);
        rst = 0; nxt();

        // load-use on rs2
        is_load = 1; rd = 5; rs2 = 5; u2 = 1;
        @(negedge clk);
        lit("lu_pc_stall", pc_stall, 1);
        lit("lu_ifid_stall", ifid_stall, 1);
        lit("lu_idex_flush", idex_flush, 1);
        nxt(); idle();
        @(negedge clk);
        lit("lu_release", pc_stall, 0);
        lit("lu_cnt", stall_cnt, 1);

        // redirect suppresses load-use
        nxt(); is_load = 1; rd = 5; rs2 = 5; u2 = 1; redirect = 1;
        @(negedge clk);
        lit("redir_flushes", {ifid_flush, idex_flush, pc_stall}, 3'b110);
        nxt(); idle();
        @(negedge clk);
        lit("redir_cnt", stall_cnt, 1);

        // MDU wait, done at cycle 4
        do_reset();
        mdu_start = 1;
        @(negedge clk);
        lit("mdu_c0", {pc_stall, exmem_flush, mdu_busy}, 3'b110);
        nxt(); mdu_start = 0;
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            lit("mdu_wait", {pc_stall, idex_stall, exmem_flush, mdu_busy}, 4'b1111);
            nxt();
        end
        mdu_done = 1;
        @(negedge clk);
        lit("mdu_done_cycle", {pc_stall, ifid_stall, idex_stall, exmem_flush, mdu_busy}, 5'b00001);
        nxt(); mdu_done = 0;
        @(negedge clk);
        lit("mdu_after", mdu_busy, 0);
        lit("mdu_cnt", stall_cnt, 4);

        // done pulse hidden behind a freeze in MDU_WAIT
        do_reset();
        mdu_start = 1; nxt(); mdu_start = 0;
        dmem_req = 1; dmem_ack = 0; nxt();
        mdu_done = 1;
        @(negedge clk);
        lit("frz_outputs", {pc_stall, exmem_stall, exmem_flush, memwb_flush}, 4'b1101);
        nxt(); mdu_done = 0; nxt();
        dmem_ack = 1;
        @(negedge clk);
        lit("frz_release", {pc_stall, exmem_flush, memwb_flush, mdu_busy}, 4'b0001);
        nxt(); idle();
        @(negedge clk);
        lit("frz_run", mdu_busy, 0);

        // memory timeout
        do_reset();
        dmem_req = 1; dmem_ack = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            lit("to_rise", mem_timeout, (i >= 4) ? 1 : 0);
            nxt();
        end
        dmem_ack = 1; nxt(); idle();
        @(negedge clk);
        lit("to_sticky", mem_timeout, 1);
        do_reset();
        @(negedge clk);
        lit("to_cleared", mem_timeout, 0);

        // reset during MDU_WAIT with freeze
        nxt(); mdu_start = 1; nxt(); mdu_start = 0; nxt();
        rst = 1; dmem_req = 1; dmem_ack = 0;
        @(negedge clk);
        lit("rst_outputs", {pc_stall, ifid_stall, idex_stall, exmem_stall, memwb_flush, exmem_flush}, 6'b0);
        nxt(); rst = 0; idle();
        @(negedge clk);
        lit("rst_busy", mdu_busy, 0);
        lit("rst_cnt", stall_cnt, 0);

        // randomized traffic
        stuck = 0;
        for (int c = 0; c < 4000; c++) begin
            nxt();
            rst = ($urandom_range(0, 299) == 0);
            rs1 = REG_W'($urandom_range(0, 3));
            rs2 = REG_W'($urandom_range(0, 3));
            rd = REG_W'($urandom_range(0, 3));
            u1 = $urandom_range(0, 1) == 1;
            u2 = $urandom_range(0, 1) == 1;
            is_load = $urandom_range(0, 2) == 0;
            redirect = $urandom_range(0, 5) == 0;
            mdu_start = $urandom_range(0, 5) == 0;
            mdu_done = $urandom_range(0, 4) == 0;
            if (stuck == 0 && $urandom_range(0, 59) == 0) stuck = $urandom_range(1, 7);
            if (stuck > 0) begin
                dmem_req = 1; dmem_ack = 0; stuck--;
            end else begin
                dmem_req = $urandom_range(0, 2) == 0;
                dmem_ack = $urandom_range(0, 3) != 0;
            end
        end
        nxt(); idle(); rst = 0;
        nxt(); nxt();
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
